// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the integer register file with a long-latency scoreboard.
// Defaults here size the register file; write-port roles are fixed by index.
package rv_rf_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned NREAD  = 2;
  localparam int unsigned NWRITE = 2;
  localparam int unsigned AW     = $clog2(NREGS);

  typedef logic [AW-1:0] reg_idx_t;

  // ALU writeback always uses the lowest port, MUL/DIV writeback the highest.
  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_MDU = NWRITE - 1;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: read ports, write ports,
// reservation request and scoreboard status.
interface regfile_scoreboard_if #(
  parameter int unsigned XLEN   = rv_rf_pkg::XLEN,
  parameter int unsigned NREGS  = rv_rf_pkg::NREGS,
  parameter int unsigned NREAD  = rv_rf_pkg::NREAD,
  parameter int unsigned NWRITE = rv_rf_pkg::NWRITE
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NREAD-1:0]       rd_busy;
  logic [NWRITE-1:0]      wr_en;
  logic [NWRITE*AW-1:0]   wr_addr;
  logic [NWRITE*XLEN-1:0] wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   rsv_ready;
  logic [AW:0]            busy_cnt;
  logic                   hazard_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ready, busy_cnt, hazard_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ready, busy_cnt, hazard_err
  );

endinterface

// File: rtl/regfile_scoreboard_pending_tracker.sv
// Pending-result scoreboard: per-register pending bits, outstanding count and sticky hazard flag.
// With RF_BYPASS_EN defined, a same-cycle MUL/DIV clear makes a register reservable.
module rf_pending_tracker #(
  parameter int unsigned NREGS  = rv_rf_pkg::NREGS,
  parameter int unsigned NWRITE = rv_rf_pkg::NWRITE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rsv_en,
  input  logic [$clog2(NREGS)-1:0]   rsv_addr,
  input  logic [NWRITE-1:0]          wr_en,
  input  logic [NWRITE*$clog2(NREGS)-1:0] wr_addr,
  output logic [NREGS-1:0]           pending,
  output logic                       rsv_ready,
  output logic [$clog2(NREGS):0]     busy_cnt,
  output logic                       hazard_err
);
  import rv_rf_pkg::*;

  localparam int unsigned AW  = $clog2(NREGS);
  localparam int unsigned MDU = NWRITE - 1;

  logic [AW-1:0]    mdu_addr;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;
  logic             clr_any;
  logic             rsv_free;
  logic             rsv_take;
  logic             side_hit;
  logic             haz_now;
  logic [NREGS-1:0] pending_nxt;
  logic [AW:0]      cnt_nxt;

  always_comb begin
    mdu_addr = wr_addr[MDU*AW +: AW];
    clr_vec  = '0;
    if (wr_en[MDU] && (mdu_addr != '0) && pending[mdu_addr])
      clr_vec[mdu_addr] = 1'b1;
    clr_any = |clr_vec;

`ifdef RF_BYPASS_EN
    rsv_free = !pending[rsv_addr] || (rsv_addr == '0) || clr_vec[rsv_addr];
`else
    rsv_free = !pending[rsv_addr] || (rsv_addr == '0);
`endif
    rsv_take = rsv_en && (rsv_addr != '0) && rsv_free;

    set_vec = '0;
    if (rsv_take)
      set_vec[rsv_addr] = 1'b1;

    // Only the non-MDU ports can overwrite a result still owed by MUL/DIV.
    side_hit = 1'b0;
    for (int unsigned p = WB_ALU; p + 1 < NWRITE; p++) begin
      if (wr_en[p] && (wr_addr[p*AW +: AW] != '0) && pending[wr_addr[p*AW +: AW]])
        side_hit = 1'b1;
    end
    haz_now = (rsv_en && !rsv_free) || side_hit;

    // Set after clear so a reservation landing on a just-retired register survives.
    pending_nxt = (pending & ~clr_vec) | set_vec;
    cnt_nxt     = busy_cnt + {{AW{1'b0}}, rsv_take} - {{AW{1'b0}}, clr_any};
  end

  assign rsv_ready = rsv_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      busy_cnt   <= '0;
      hazard_err <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      busy_cnt   <= cnt_nxt;
      hazard_err <= hazard_err | haz_now;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file: NREAD combinational reads, NWRITE prioritised writes, x0 hard-wired,
// plus a pending scoreboard for MUL/DIV results. RF_BYPASS_EN enables same-cycle forwarding.
module regfile_scoreboard #(
  parameter int unsigned XLEN   = rv_rf_pkg::XLEN,
  parameter int unsigned NREGS  = rv_rf_pkg::NREGS,
  parameter int unsigned NREAD  = rv_rf_pkg::NREAD,
  parameter int unsigned NWRITE = rv_rf_pkg::NWRITE
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);
  import rv_rf_pkg::*;

  localparam int unsigned AW = $clog2(NREGS);
`ifdef RF_BYPASS_EN
  localparam int unsigned MDU = NWRITE - 1;
`endif

  logic [XLEN-1:0]       regs [NREGS];
  logic [NREGS-1:0]      pending;
  logic [NREAD*XLEN-1:0] rd_data_c;
  logic [NREAD-1:0]      rd_busy_c;
  logic                  rsv_ready_c;
  logic [AW:0]           busy_cnt_c;
  logic                  hazard_c;

  rf_pending_tracker #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE)
  ) u_pending (
    .clk        (clk),
    .rst        (rst),
    .rsv_en     (bus.rsv_en),
    .rsv_addr   (bus.rsv_addr),
    .wr_en      (bus.wr_en),
    .wr_addr    (bus.wr_addr),
    .pending    (pending),
    .rsv_ready  (rsv_ready_c),
    .busy_cnt   (busy_cnt_c),
    .hazard_err (hazard_c)
  );

  // Ascending port order: the highest-indexed port writing an index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++)
        regs[r] <= '0;
    end else begin
      for (int unsigned p = WB_ALU; p < NWRITE; p++) begin
        if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0))
          regs[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned i = 0; i < NREAD; i++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            b;
      a = bus.rd_addr[i*AW +: AW];
      d = regs[a];
      b = pending[a];
`ifdef RF_BYPASS_EN
      for (int unsigned p = WB_ALU; p < NWRITE; p++) begin
        if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == a))
          d = bus.wr_data[p*XLEN +: XLEN];
      end
      if (bus.wr_en[MDU] && (bus.wr_addr[MDU*AW +: AW] == a))
        b = 1'b0;
`endif
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end
      rd_data_c[i*XLEN +: XLEN] = d;
      rd_busy_c[i]              = b;
    end
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.rd_busy    = rd_busy_c;
  assign bus.rsv_ready  = rsv_ready_c;
  assign bus.busy_cnt   = busy_cnt_c;
  assign bus.hazard_err = hazard_c;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed vectors push expectations, a negedge
// monitor pops and compares. Expectations follow RF_BYPASS_EN when it is defined.
module tb_regfile_scoreboard;
  import rv_rf_pkg::*;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [5:0]  cnt;
    logic        haz;
    logic        rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mon_req = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) bus ();

  regfile_scoreboard #(.XLEN(32), .NREGS(32), .NREAD(2), .NWRITE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor actual=empty_queue required=expectation");
      end else begin
        e = q.pop_front();
        cmp(e.name, "rd_data0",   bus.rd_data[31:0],        e.d0);
        cmp(e.name, "rd_busy0",   32'(bus.rd_busy[0]),      32'(e.b0));
        cmp(e.name, "rd_data1",   bus.rd_data[63:32],       e.d1);
        cmp(e.name, "rd_busy1",   32'(bus.rd_busy[1]),      32'(e.b1));
        cmp(e.name, "busy_cnt",   32'(bus.busy_cnt),        32'(e.cnt));
        cmp(e.name, "hazard_err", 32'(bus.hazard_err),      32'(e.haz));
        cmp(e.name, "rsv_ready",  32'(bus.rsv_ready),       32'(e.rdy));
      end
    end
  end

  task automatic expect_now(input string n, input logic [31:0] d0, input logic b0,
                            input logic [31:0] d1, input logic b1, input logic [5:0] cnt,
                            input logic haz, input logic rdy);
    exp_t e;
    e = '{name: n, d0: d0, b0: b0, d1: d1, b1: b1, cnt: cnt, haz: haz, rdy: rdy};
    q.push_back(e);
    mon_req = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    mon_req     = 1'b0;
    bus.wr_en   = '0;
    bus.rsv_en  = 1'b0;
  endtask

  task automatic wr(input int p, input reg_idx_t a, input logic [31:0] d);
    bus.wr_en[p]          = 1'b1;
    bus.wr_addr[p*5 +: 5] = a;
    bus.wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input reg_idx_t a0, input reg_idx_t a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic rsv(input logic en, input reg_idx_t a);
    bus.rsv_en   = en;
    bus.rsv_addr = a;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.rd_addr = '0;
    @(posedge clk); #1;

    rd(5, 31); rsv(1'b0, 5);
    expect_now("reset", 0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    rst = 1'b0;

    rd(3, 0); rsv(1'b0, 0); wr(0, 3, 32'hDEADBEEF); wr(1, 0, 32'h1234);
    expect_now("wr_x3_same", BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0, 0, 0, 1);
    next_cycle();

    rd(3, 7); wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    expect_now("wr_x7_same", 32'hDEADBEEF, 0, BYP ? 32'h22 : 32'h0, 0, 0, 0, 1);
    next_cycle();

    rd(7, 0); rsv(1'b1, 10);
    expect_now("prio_x7_x0", 32'h22, 0, 0, 0, 0, 0, 1);
    next_cycle();

    rd(10, 7); rsv(1'b0, 10);
    expect_now("rsv_x10", 0, 1, 32'h22, 0, 1, 0, 0);
    next_cycle();

    rd(10, 3); rsv(1'b1, 10);
    expect_now("rsv_again", 0, 1, 32'hDEADBEEF, 0, 1, 0, 0);
    next_cycle();

    rd(12, 10); rsv(1'b1, 12);
    expect_now("hazard_rsv", 0, 0, 0, 1, 1, 1, 1);
    next_cycle();

    rd(12, 10); rsv(1'b0, 10); wr(0, 12, 32'hABCD); wr(1, 10, 32'h99);
    expect_now("side_wr_clr", BYP ? 32'hABCD : 32'h0, 1, BYP ? 32'h99 : 32'h0, !BYP, 2, 1, BYP);
    next_cycle();

    rd(12, 10); rsv(1'b1, 12); wr(1, 12, 32'h77);
    expect_now("rsv_and_clr", BYP ? 32'h77 : 32'hABCD, !BYP, 32'h99, 0, 1, 1, BYP);
    next_cycle();

    rd(12, 4); rsv(1'b0, 0); wr(0, 4, 32'h55);
    expect_now("x4_fwd", 32'h77, BYP, BYP ? 32'h55 : 32'h0, 0, BYP ? 6'd1 : 6'd0, 1, 1);
    next_cycle();

    rd(4, 12);
    expect_now("x4_next", 32'h55, 0, 32'h77, BYP, BYP ? 6'd1 : 6'd0, 1, 1);
    next_cycle();

    rd(4, 12); wr(0, 5, 32'h5555); wr(1, 6, 32'h6666); rsv(1'b1, 20);
    rst = 1'b1;
    expect_now("rst_mid_burst", 0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    rst = 1'b0;

    rd(5, 6);
    expect_now("burst_lost", 0, 0, 0, 0, 0, 0, 1);
    next_cycle();

    rd(3, 10);
    expect_now("regs_cleared", 0, 0, 0, 0, 0, 0, 1);
    next_cycle();

    next_cycle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the core's integer register file: NREAD combinational read ports, NWRITE synchronous write ports, and a per-register pending scoreboard for long-latency RV32M results (MUL/DIV). Sits between decode (reads, reservations) and the writeback stages (ALU writeback on port 0, MUL/DIV writeback on port NWRITE-1). Adds async reset clearing, x0 hard-wiring, write-port priority, an outstanding-result counter and hazard detection.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
NREAD, 2, number of read ports
NWRITE, 2, number of write ports; port NWRITE-1 is the long-latency port
AW (localparam), $clog2(NREGS), register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
rd_addr  in  NREAD*AW  packed read indices, port i at [i*AW +: AW]
rd_data  out  NREAD*XLEN  packed read data, combinational
rd_busy  out  NREAD  read register has a pending long-latency result
wr_en  in  NWRITE  write enable per port
wr_addr  in  NWRITE*AW  packed write indices
wr_data  in  NWRITE*XLEN  packed write data
rsv_en  in  1  reserve rsv_addr for a long-latency result
rsv_addr  in  AW  register to reserve
rsv_ready  out  1  reservation would be accepted this cycle
busy_cnt  out  AW+1  number of pending registers
hazard_err  out  1  sticky hazard flag

Behaviour:
- Clock is clk; reset is asynchronous, active-high (rst); single clock domain.
- Reset: all registers 0, all pending bits 0, busy_cnt=0, hazard_err=0; rd_data reflects zeros immediately, rd_busy=0, rsv_ready=1.
- Reads: combinational, zero latency; index 0 always returns 0 and rd_busy=0.
- Writes: take effect at rising clk; writes to index 0 ignored. Same index on several ports in one cycle: highest port index wins.
- Pending: a write on port NWRITE-1 to a pending register clears its bit. Port 0..NWRITE-2 writes never clear pending.
- Reservation: rsv_ready = !pending[rsv_addr] || rsv_addr==0. rsv_en && rsv_addr!=0 && rsv_ready -> pending bit set at next edge.
- Simultaneous reserve and clear of the same register: bit stays 1 (new reservation wins; rsv_ready is computed from the current state, so this only occurs for a newly free register); busy_cnt unchanged.
- busy_cnt: +1 per accepted reservation, -1 per clear, net in the same cycle; never wraps (max NREGS-1).
- hazard_err set at edge when rsv_en with rsv_ready=0 (request dropped, no state change), or when a port < NWRITE-1 writes a pending register (data still written). Cleared only by rst.
- rst asserted mid-operation: all state cleared immediately, in-flight writes lost.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: same-cycle forwarding. rd_data returns the winning same-cycle wr_data for a matching nonzero index. rd_busy=0 if port NWRITE-1 writes that register this cycle; rsv_ready likewise sees the clear.
- Undefined: rd_data/rd_busy/rsv_ready reflect registered state only; writes are visible next cycle.

Decomposition:
- Package rv_rf_pkg: XLEN, NREGS, reg index typedef, write-port constants WB_ALU=0, WB_MDU=NWRITE-1.
- One sub-module, rf_pending_tracker: pending bit vector, busy_cnt and the hazard_err logic. The register array stays in the top.

Test Plan:
- Reset then read x5, x31 -> rd_data=0, rd_busy=0, busy_cnt=0.
- Write x3=0xDEADBEEF on port 0; next cycle read x3 -> 0xDEADBEEF. Write x0=0x1234 -> x0 reads 0.
- Ports 0 and 1 both write x7 (0x11, 0x22) in one cycle -> x7=0x22.
- Reserve x10 -> rsv_ready for x10 goes 0, rd_busy=1, busy_cnt=1; port 1 writes x10=0x99 -> busy cleared, busy_cnt=0, x10=0x99.
- Reserve x10 while pending -> hazard_err=1, busy_cnt unchanged; port 0 writes pending x12 -> hazard_err=1, x12 updated.
- With RF_BYPASS_EN: port 0 writes x4=0x55 and reads x4 in the same cycle -> rd_data=0x55. Without it -> old value. Assert rst mid-burst -> all outputs return to reset values asynchronously.
